// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: fetches a 9-bit instruction plus immediate from the program ROM,
// decodes it into register-file/ALU strobes and advances the ROM with a one-cycle step pulse.
module instr_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [8:0]  instruction,
    input  logic [15:0] data_var,
    output logic        step,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [1:0]  alu_op,
    output logic        wb_sel,
    output logic [15:0] imm,
    output logic        reg_we,
    output logic [2:0]  wr_addr,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [7:0]  retired
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWrite,
        StAdvance,
        StHalt
    } state_e;

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpMov  = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpTerm = 3'b100;

    localparam logic [1:0] AluPassB = 2'b00;
    localparam logic [1:0] AluAdd   = 2'b01;
    localparam logic [1:0] AluXor   = 2'b10;

    state_e     state;
    logic [8:0] ir;

    // Register addresses come straight from the latched instruction word.
    assign rd_addr_a = ir[5:3];
    assign rd_addr_b = ir[2:0];
    assign wr_addr   = ir[5:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            ir      <= '0;
            imm     <= '0;
            alu_op  <= AluPassB;
            wb_sel  <= 1'b0;
            reg_we  <= 1'b0;
            step    <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            reg_we <= 1'b0;
            step   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (run) begin
                        state <= StFetch;
                        busy  <= 1'b1;
                    end
                end
                StFetch: begin
                    ir    <= instruction;
                    imm   <= data_var;
                    state <= StDecode;
                    // Control settings are loaded here so they are valid throughout DECODE..WRITE.
                    case (instruction[8:6])
                        OpLoad: begin
                            wb_sel <= 1'b1;
                            alu_op <= AluPassB;
                        end
                        OpMov: begin
                            wb_sel <= 1'b0;
                            alu_op <= AluPassB;
                        end
                        OpAdd: begin
                            wb_sel <= 1'b0;
                            alu_op <= AluAdd;
                        end
                        OpXor: begin
                            wb_sel <= 1'b0;
                            alu_op <= AluXor;
                        end
                        default: begin
                            wb_sel <= 1'b0;
                            alu_op <= AluPassB;
                        end
                    endcase
                end
                StDecode: begin
                    case (ir[8:6])
                        OpLoad, OpMov: begin
                            state  <= StWrite;
                            reg_we <= 1'b1;
                        end
                        OpAdd, OpXor: begin
                            state <= StExec;
                        end
                        OpTerm: begin
                            state  <= StHalt;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        default: begin
                            state   <= StHalt;
                            busy    <= 1'b0;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                StExec: begin
                    state  <= StWrite;
                    reg_we <= 1'b1;
                end
                StWrite: begin
                    // The retire count moves together with the step pulse.
                    state   <= StAdvance;
                    step    <= 1'b1;
                    retired <= retired + 8'd1;
                    alu_op  <= AluPassB;
                    wb_sel  <= 1'b0;
                end
                StAdvance: begin
                    state <= StFetch;
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: ROM and register-file harness around instr_sequencer, with a program-level
// reference model giving expected register contents, write order, retire count and step spacing.
module tb_instr_sequencer;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic [15:0] d;
    } instr_t;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] val;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [8:0]  instruction;
    logic [15:0] data_var;
    logic        step;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [1:0]  alu_op;
    logic        wb_sel;
    logic [15:0] imm;
    logic        reg_we;
    logic [2:0]  wr_addr;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [7:0]  retired;

    instr_t      rom [4096];
    int          rom_addr = 0;
    instr_t      cur;
    logic [15:0] rf [8];

    int     n_tests = 0;
    int     n_fail = 0;
    int     tb_cyc = 0;
    int     mon_cyc = 0;
    int     nsteps = 0;
    int     last_step = 0;
    bit     have_last = 0;
    bit     prev_step = 0;
    int     gaps[$];
    wr_t    exp_q[$];
    instr_t prog[$];

    logic [15:0] exp_rf [8];
    int          exp_lat[$];
    int          exp_sum;
    int          exp_ret;
    bit          exp_ill;
    int          t0;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instruction (instruction),
        .data_var    (data_var),
        .step        (step),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .imm         (imm),
        .reg_we      (reg_we),
        .wr_addr     (wr_addr),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    assign cur         = rom[rom_addr[11:0]];
    assign instruction = {cur.op, cur.rx, cur.ry};
    assign data_var    = cur.d;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
        case (op)
            2'b00:   return b;
            2'b01:   return a + b;
            2'b10:   return a ^ b;
            default: return 16'hdead;
        endcase
    endfunction

    function automatic instr_t mk(input int op, input int rx, input int ry, input int d);
        instr_t i;
        i.op = 3'(op);
        i.rx = 3'(rx);
        i.ry = 3'(ry);
        i.d  = 16'(d);
        return i;
    endfunction

    // Datapath harness and step monitor, sampled mid-cycle.
    always @(negedge clk) begin : harness
        logic [15:0] v;
        wr_t         e;
        mon_cyc++;
        if (!rst && reg_we) begin
            v = wb_sel ? imm : alu(alu_op, rf[rd_addr_a], rf[rd_addr_b]);
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", wr_addr, e.addr);
                check("write_value", v, e.val);
            end
            rf[wr_addr] = v;
        end
        if (!rst && step) begin
            check("step_width", prev_step, 0);
            check("step_we_overlap", reg_we, 0);
            if (have_last) gaps.push_back(mon_cyc - last_step);
            last_step = mon_cyc;
            have_last = 1;
            nsteps++;
            rom_addr++;
        end
        prev_step = step;
    end

    // Place prog at the current ROM address and derive expectations from the instruction rules.
    task automatic load_prog();
        bit done;
        for (int i = 0; i < prog.size(); i++) rom[(rom_addr + i) % 4096] = prog[i];
        for (int r = 0; r < 8; r++) exp_rf[r] = rf[r];
        exp_lat.delete();
        exp_sum = 0;
        exp_ret = 0;
        exp_ill = 0;
        done    = 0;
        for (int i = 0; i < prog.size() && !done; i++) begin
            case (prog[i].op)
                3'd0: exp_rf[prog[i].rx] = prog[i].d;
                3'd1: exp_rf[prog[i].rx] = exp_rf[prog[i].ry];
                3'd2: exp_rf[prog[i].rx] = exp_rf[prog[i].rx] + exp_rf[prog[i].ry];
                3'd3: exp_rf[prog[i].rx] = exp_rf[prog[i].rx] ^ exp_rf[prog[i].ry];
                3'd4: done = 1;
                default: begin
                    done    = 1;
                    exp_ill = 1;
                end
            endcase
            if (!done) begin
                exp_q.push_back('{addr: prog[i].rx, val: exp_rf[prog[i].rx]});
                exp_lat.push_back(prog[i].op < 3'd2 ? 4 : 5);
                exp_sum += prog[i].op < 3'd2 ? 4 : 5;
                exp_ret++;
            end
        end
    endtask

    // Reset, then pulse run; returns #1 into the first FETCH cycle.
    task automatic start_run();
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        nsteps    = 0;
        have_last = 0;
        gaps.delete();
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        t0 = tb_cyc;
    endtask

    task automatic finish_run(input int budget);
        int bad;
        while (!halted && (tb_cyc - t0) < budget) begin
            @(posedge clk);
            #1;
        end
        check("halt_latency", tb_cyc - t0, exp_sum + 2);
        check("halted", halted, 1);
        check("busy_after_halt", busy, 0);
        check("illegal", illegal, exp_ill);
        check("retired", retired, exp_ret % 256);
        check("step_count", nsteps, exp_ret);
        check("gap_count", gaps.size(), exp_ret > 0 ? exp_ret - 1 : 0);
        bad = 0;
        for (int k = 0; k < gaps.size(); k++)
            if (k + 1 >= exp_lat.size() || gaps[k] != exp_lat[k + 1]) bad++;
        check("step_spacing", bad, 0);
        check("writes_pending", exp_q.size(), 0);
        exp_q.delete();
        for (int r = 0; r < 8; r++) check($sformatf("rf_r%0d", r), rf[r], exp_rf[r]);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = '0;
        for (int r = 0; r < 8; r++) rf[r] = '0;

        // Reset state
        @(negedge clk);
        check("rst_step", step, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_retired", retired, 0);
        check("rst_imm", imm, 0);
        check("rst_ctrl", {alu_op, wb_sel, rd_addr_a, rd_addr_b, wr_addr}, 0);
        rst = 1'b0;

        // Load timing
        prog.delete();
        prog.push_back(mk(0, 0, 0, 16'h0001));
        prog.push_back(mk(4, 0, 0, 0));
        load_prog();
        start_run();
        check("ld_fetch_busy", busy, 1);
        check("ld_fetch_we", reg_we, 0);
        @(posedge clk); #1;
        check("ld_dec_wbsel", wb_sel, 1);
        check("ld_dec_we", reg_we, 0);
        @(posedge clk); #1;
        check("ld_wr_we", reg_we, 1);
        check("ld_wr_addr", wr_addr, 0);
        check("ld_wr_wbsel", wb_sel, 1);
        check("ld_wr_aluop", alu_op, 0);
        check("ld_wr_imm", imm, 16'h0001);
        check("ld_wr_step", step, 0);
        @(posedge clk); #1;
        check("ld_adv_step", step, 1);
        check("ld_adv_we", reg_we, 0);
        check("ld_adv_ctrl", {alu_op, wb_sel}, 0);
        @(posedge clk); #1;
        check("ld_next_step", step, 0);
        check("ld_retired", retired, 1);
        finish_run(20);

        // Add timing
        prog.delete();
        prog.push_back(mk(2, 2, 1, 0));
        prog.push_back(mk(4, 0, 0, 0));
        load_prog();
        start_run();
        @(posedge clk); #1;
        check("add_dec_ra", rd_addr_a, 2);
        check("add_dec_rb", rd_addr_b, 1);
        check("add_dec_aluop", alu_op, 1);
        @(posedge clk); #1;
        check("add_exec_we", reg_we, 0);
        check("add_exec_ra", rd_addr_a, 2);
        check("add_exec_rb", rd_addr_b, 1);
        @(posedge clk); #1;
        check("add_wr_we", reg_we, 1);
        check("add_wr_aluop", alu_op, 1);
        check("add_wr_wbsel", wb_sel, 0);
        check("add_wr_addr", wr_addr, 2);
        @(posedge clk); #1;
        check("add_adv_step", step, 1);
        finish_run(20);

        // Reset while a write strobe is in flight
        rom[rom_addr % 4096]       = mk(0, 1, 0, 16'h1111);
        rom[(rom_addr + 1) % 4096] = mk(0, 5, 0, 16'hABCD);
        exp_q.push_back('{addr: 3'd1, val: 16'h1111});
        start_run();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        check("mid_we_before", reg_we, 1);
        check("mid_retired_before", retired, 1);
        check("mid_addr_before", wr_addr, 5);
        #2 rst = 1'b1;
        #1;
        check("mid_we", reg_we, 0);
        check("mid_step", step, 0);
        check("mid_busy", busy, 0);
        check("mid_retired", retired, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("mid_idle_busy", busy, 0);
        check("mid_idle_steps", nsteps, 1);
        check("mid_rf5_untouched", 32'(rf[5] != 16'hABCD), 1);
        exp_q.delete();

        // Full directed program
        prog.delete();
        for (int r = 0; r < 4; r++) prog.push_back(mk(0, r, 0, r + 1));
        prog.push_back(mk(0, 0, 0, 5));
        prog.push_back(mk(3, 1, 3, 0));
        prog.push_back(mk(1, 2, 1, 0));
        prog.push_back(mk(2, 2, 1, 0));
        prog.push_back(mk(2, 3, 1, 0));
        prog.push_back(mk(3, 0, 3, 0));
        prog.push_back(mk(4, 0, 0, 0));
        load_prog();
        start_run();
        finish_run(80);

        // Illegal opcode, then run ignored, then reset clears
        prog.delete();
        prog.push_back(mk(6, 3, 2, 16'h5555));
        load_prog();
        start_run();
        finish_run(20);
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        run = 1'b0;
        check("ill_run_halted", halted, 1);
        check("ill_run_busy", busy, 0);
        check("ill_run_steps", nsteps, 0);
        rst = 1'b1;
        #1;
        check("ill_rst_illegal", illegal, 0);
        check("ill_rst_halted", halted, 0);
        @(negedge clk);
        rst = 1'b0;

        // Random programs
        for (int t = 0; t < 6; t++) begin
            int len;
            prog.delete();
            len = $urandom_range(3, 12);
            for (int i = 0; i < len; i++)
                prog.push_back(mk($urandom_range(0, 3), $urandom_range(0, 7),
                                  $urandom_range(0, 7), $urandom));
            if ($urandom_range(0, 1) == 1) prog.push_back(mk(4, 0, 0, 0));
            else prog.push_back(mk($urandom_range(5, 7), $urandom_range(0, 7), 0, 0));
            load_prog();
            start_run();
            finish_run(len * 5 + 10);
        end

        // Retire counter wrap
        prog.delete();
        for (int i = 0; i < 256; i++) prog.push_back(mk(0, $urandom_range(0, 7), 0, $urandom));
        prog.push_back(mk(4, 0, 0, 0));
        load_prog();
        start_run();
        finish_run(256 * 4 + 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
